// File: rtl/alarm_clock_core_if.sv
// Pulse inputs and display/status outputs of the alarm clock core.
// The core drives the slave side; the button/display logic drives the master side.
interface alarm_clock_core_if #(
    parameter int NUM_ALARMS = 2
);
    localparam int AW = $clog2(NUM_ALARMS + 1);

    logic          set_pulse;
    logic          add_pulse;
    logic          beep_pulse;
    logic [23:0]   time_bcd;
    logic [23:0]   disp_bcd;
    logic [5:0]    disp_blank;
    logic [AW-1:0] edit_target;
    logic [1:0]    edit_field;
    logic          beep_enabled;
    logic          ringing;
    logic [AW-1:0] ring_id;

    modport master (
        output set_pulse, add_pulse, beep_pulse,
        input  time_bcd, disp_bcd, disp_blank, edit_target, edit_field,
               beep_enabled, ringing, ring_id
    );

    modport slave (
        input  set_pulse, add_pulse, beep_pulse,
        output time_bcd, disp_bcd, disp_blank, edit_target, edit_field,
               beep_enabled, ringing, ring_id
    );
endinterface

// File: rtl/alarm_clock_core.sv
// BCD hh:mm:ss timekeeper with NUM_ALARMS alarms, field editing, blink mask and ringing.
// Pulse effects are registered (1 cycle); pulses are always accepted, no backpressure.
module alarm_clock_core #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int NUM_ALARMS   = 2,
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int RING_SEC     = 60
) (
    input  logic               clk,
    input  logic               rst,
    alarm_clock_core_if.slave  bus
);
    localparam int AW = $clog2(NUM_ALARMS + 1);
    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    typedef enum logic [1:0] {
        FLD_RUN = 2'd0,
        FLD_SEC = 2'd1,
        FLD_MIN = 2'd2,
        FLD_HR  = 2'd3
    } field_e;

    field_e        r_field, w_field_nxt;
    logic [AW-1:0] r_target, w_target_nxt;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_time;
    logic [23:0]   r_alarm [NUM_ALARMS];
    logic          r_beep;
    logic          r_ring;
    logic [AW-1:0] r_ring_id;
    logic [7:0]    r_ring_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_phase;
    logic [5:0]    r_blank;

    logic          w_run, w_tick, w_set, w_add, w_match;
    logic [AW-1:0] w_match_id;
    logic [23:0]   w_time_tick, w_edit_src, w_edited;
    logic [5:0]    w_mask;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_run  = (r_field == FLD_RUN);
    assign w_tick = w_run && (r_presc == PW'(CLK_HZ - 1));
    // While ringing every pulse is consumed as a dismiss and does nothing else.
    assign w_add  = bus.add_pulse && !r_ring && !w_run;
    assign w_set  = bus.set_pulse && !bus.add_pulse && !r_ring;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_field  <= FLD_RUN;
            r_target <= '0;
        end else begin
            r_field  <= w_field_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_field_nxt  = r_field;
        w_target_nxt = r_target;
        if (w_set) begin
            case (r_field)
                FLD_RUN: begin
                    w_field_nxt  = FLD_SEC;
                    w_target_nxt = '0;
                end
                FLD_SEC: w_field_nxt = FLD_MIN;
                FLD_MIN: w_field_nxt = FLD_HR;
                default: begin
                    if (r_target == AW'(NUM_ALARMS)) begin
                        w_field_nxt  = FLD_RUN;
                        w_target_nxt = '0;
                    end else begin
                        w_field_nxt  = FLD_SEC;
                        w_target_nxt = r_target + AW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_time_tick = r_time;
        w_time_tick[7:0] = bcd_inc(r_time[7:0], 8'h59);
        if (r_time[7:0] == 8'h59)
            w_time_tick[15:8] = bcd_inc(r_time[15:8], 8'h59);
        if (r_time[15:0] == 16'h5959)
            w_time_tick[23:16] = bcd_inc(r_time[23:16], 8'h23);

        w_edit_src = r_time;
        for (int k = 0; k < NUM_ALARMS; k++)
            if (r_target == AW'(k + 1))
                w_edit_src = r_alarm[k];

        w_edited = w_edit_src;
        case (r_field)
            FLD_SEC: w_edited[7:0]   = bcd_inc(w_edit_src[7:0], 8'h59);
            FLD_MIN: w_edited[15:8]  = bcd_inc(w_edit_src[15:8], 8'h59);
            FLD_HR:  w_edited[23:16] = bcd_inc(w_edit_src[23:16], 8'h23);
            default: w_edited = w_edit_src;
        endcase

        // Scan downwards so the lowest-numbered matching alarm wins.
        w_match    = 1'b0;
        w_match_id = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (r_alarm[k] == w_time_tick) begin
                w_match    = 1'b1;
                w_match_id = AW'(k + 1);
            end
        end

        case (r_field)
            FLD_SEC: w_mask = 6'b000011;
            FLD_MIN: w_mask = 6'b001100;
            FLD_HR:  w_mask = 6'b110000;
            default: w_mask = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc     <= '0;
            r_time      <= '0;
            for (int k = 0; k < NUM_ALARMS; k++)
                r_alarm[k] <= '0;
            r_beep      <= 1'b0;
            r_ring      <= 1'b0;
            r_ring_id   <= '0;
            r_ring_cnt  <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_blank     <= '0;
        end else begin
            r_presc <= (w_run && !w_tick) ? r_presc + PW'(1) : '0;

            if (w_tick)
                r_time <= w_time_tick;
            else if (w_add && r_target == '0)
                r_time <= w_edited;
            for (int k = 0; k < NUM_ALARMS; k++)
                if (w_add && r_target == AW'(k + 1))
                    r_alarm[k] <= w_edited;

            if (bus.beep_pulse && !r_ring)
                r_beep <= ~r_beep;

            if (r_ring) begin
                if (bus.set_pulse || bus.add_pulse || bus.beep_pulse || !r_beep || !w_run) begin
                    r_ring    <= 1'b0;
                    r_ring_id <= '0;
                end else if (w_tick) begin
                    if (r_ring_cnt == 8'(RING_SEC - 1)) begin
                        r_ring    <= 1'b0;
                        r_ring_id <= '0;
                    end else begin
                        r_ring_cnt <= r_ring_cnt + 8'd1;
                    end
                end
            end else if (w_tick && r_beep && w_match) begin
                r_ring     <= 1'b1;
                r_ring_id  <= w_match_id;
                r_ring_cnt <= '0;
            end

            if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
            r_blank <= r_phase ? w_mask : 6'b000000;
        end
    end

    assign bus.time_bcd     = r_time;
    assign bus.disp_bcd     = w_edit_src;
    assign bus.disp_blank   = r_blank;
    assign bus.edit_target  = r_target;
    assign bus.edit_field   = r_field;
    assign bus.beep_enabled = r_beep;
    assign bus.ringing      = r_ring;
    assign bus.ring_id      = r_ring_id;
endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Single-clock, parametrised timekeeping and alarm core. It keeps hh:mm:ss in BCD, provides NUM_ALARMS independently settable alarms, and handles field editing with blink masking and alarm ringing with timeout and dismiss. The core sits between the button debouncers and the 7-segment decoder/scan path. All time bases are clock enables derived from `clk`; the core uses no derived clocks.

## Interface
Parameters:
- CLK_HZ, 50_000_000, `clk` cycles per second tick (≥2)
- NUM_ALARMS, 2, number of alarm registers (1..7)
- BLINK_CYCLES, 12_500_000, half-period of the edit blink, in `clk` cycles
- RING_SEC, 60, seconds an alarm rings before auto-stop (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- set_pulse  in  1  debounced one-cycle pulse; advances the edit state
- add_pulse  in  1  debounced one-cycle pulse; increments the selected field
- beep_pulse  in  1  debounced one-cycle pulse; toggles the alarm master enable
- time_bcd  out  24  current time {H1,H0,M1,M0,S1,S0}, BCD
- disp_bcd  out  24  time shown on the display: current time, or the alarm being edited
- disp_blank  out  6  per-digit blank mask, bit 5 = H1
- edit_target  out  AW  0 = running/time, k = alarm k; AW = $clog2(NUM_ALARMS+1)
- edit_field  out  2  0 = none (RUN), 1 = seconds, 2 = minutes, 3 = hours
- beep_enabled  out  1  alarm master enable
- ringing  out  1  an alarm is sounding
- ring_id  out  AW  alarm that triggered (0 when not ringing)

## Operation
- **Reset.** time_bcd = 0, all alarms = 0, beep_enabled = 0, ringing = 0, ring_id = 0, state RUN (target 0, field 0), prescaler = 0, blink phase = 0, disp_blank = 0.
- **Prescaler.** Counts 0..CLK_HZ-1. It is held at 0 outside RUN. `tick` is asserted when the count is CLK_HZ-1.
- **RUN.** On tick, seconds increment. 59→00 carries into minutes; minutes 59→00 carries into hours; 23:59:59→00:00:00. Each BCD digit stays within 0..9 and the tens digits stay within their limits.
- **Edit FSM.** The states, in order, are: RUN → (t0,S) → (t0,M) → (t0,H) → (t1,S) → … → (tN,H) → RUN. Each set_pulse advances one state. Total states = 1 + 3·(NUM_ALARMS+1).
- **Time during edit.** Time does not advance while edit_field ≠ 0. On return to RUN the prescaler restarts from 0.
- **add_pulse in an edit state.** Increments only the selected field of the selected target. Seconds and minutes wrap 59→00; hours wrap 23→00. No carry into the next field.
- **add_pulse in RUN.** No effect.
- **set and add in the same cycle.** add is applied; set is ignored.
- **disp_bcd.** Shows alarm k when edit_target = k ≥ 1; otherwise shows time_bcd.
- **Blink.** The blink counter runs always. Phase toggles every BLINK_CYCLES cycles. When phase = 1, disp_blank = 2'b11 at the selected field's digit pair; otherwise disp_blank = 0. In RUN, disp_blank = 0.
- **beep_pulse.** When not ringing, toggles beep_enabled, in any state. When ringing, it dismisses the alarm and does not toggle.
- **Alarm trigger.** In RUN, on the cycle the tick update makes time_bcd equal to alarm k while beep_enabled = 1:
  - ringing is set and ring_id = k.
  - If several alarms match, the lowest k wins.
  - A match produced by editing never triggers.
  - A match while already ringing is ignored.
- **Ring stop.** Ringing clears on whichever comes first: RING_SEC ticks after the start, any set/add/beep pulse (the pulse is consumed with no other effect), beep_enabled going 0, or leaving RUN.
- **Reset mid-operation.** All state returns to reset values immediately, including alarms and the edit FSM.

## Timing
- tick is asserted at prescaler count CLK_HZ-1. time_bcd updates on the next edge, which is one tick every CLK_HZ cycles.
- ringing and ring_id are registered in the same edge as the time update that produces the match. They are visible together with the new time_bcd.
- set_pulse/add_pulse effects appear on time_bcd, disp_bcd, edit_target and edit_field one cycle after the pulse.
- Ring duration is exactly RING_SEC ticks: ringing falls on the edge of the RING_SEC-th tick after the start.
- The dismiss pulse clears ringing on the next edge.
- disp_blank is registered; it changes one cycle after the blink phase or the edit state changes.

## Test plan
Use CLK_HZ=4, BLINK_CYCLES=2, NUM_ALARMS=2, RING_SEC=3 unless a line says otherwise.
- **Wrap-around.** Preload 23:59:58 by editing; return to RUN; wait 8 cycles → time_bcd = 00:00:00 after the 2nd tick, with no change between ticks.
- **Edit no-carry.** Seconds at 59, add_pulse in (t0,S) → 00, minutes unchanged. Hours at 23, add → 00.
- **Full FSM cycle.** 9 set_pulses → edit_target/edit_field sequence (0,1)(0,2)(0,3)(1,1)…(2,3); the 10th pulse → RUN (0,0). Same-cycle set+add → field increments and the state holds.
- **Alarm trigger and timeout.** Alarm1 = 00:00:05, beep_enabled = 1, time from 0 → ringing = 1, ring_id = 1 on the edge where time_bcd = 00:00:05; ringing = 0 at 00:00:08. Repeat with beep_enabled = 0 → no ring.
- **Priority and dismiss.** Alarm1 = alarm2 = 00:00:02 → ring_id = 1. Pulse beep_pulse while ringing → ringing = 0 next cycle, beep_enabled still 1.
- **Blink and async reset.** In (1,2): disp_bcd = alarm1, disp_blank toggles 6'b001100 / 0 every 2 cycles. Assert rst mid-edit → all outputs return to reset values without a clock edge.
